acc_share_ctrl: RTL and testbench

- Round-robin controller that shares one 8-bit accumulator datapath (4-bit addend, 8-bit running sum) among NREQ requesters.
- Sequences each transaction through a request, grant, accumulate and ack cycle.
- Also handles clear, overflow flagging and abort.
- Sits between several producer blocks and the single accumulator register; each producer sees a simple req/gnt/ack handshake.

---
 rtl/acc_share_ctrl_if.sv | 27 ++
 rtl/acc_share_ctrl.sv | 176 +++++++++++++++++
 tb/tb_acc_share_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/acc_share_ctrl_if.sv
// Handshake bundle between the producers and the shared accumulator controller.
// The producer side drives req/data/clr_req; the controller returns grant, ack and the running sum.
interface acc_share_ctrl_if #(
   parameter int NREQ = 4,
   parameter int DW   = 4,
   parameter int AW   = 8
);
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] data;
   logic               clr_req;
   logic [NREQ-1:0]    gnt;
   logic [2:0]         owner;
   logic               ack;
   logic               busy;
   logic [AW-1:0]      acc_out;
   logic               ovf;

   modport master (
      output req, data, clr_req,
      input  gnt, owner, ack, busy, acc_out, ovf
   );

   modport slave (
      input  req, data, clr_req,
      output gnt, owner, ack, busy, acc_out, ovf
   );
endinterface

// File: rtl/acc_share_ctrl.sv
// Round-robin sharing of one accumulator among NREQ requesters: IDLE -> GRANT -> ACCUM per add.
// Define ACC_SHARE_SAT_EN to saturate the sum on carry-out instead of wrapping.
module acc_share_ctrl #(
   parameter int NREQ = 4,
   parameter int DW   = 4,
   parameter int AW   = 8
) (
   input  logic               clk,
   input  logic               reset,
   acc_share_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_ACCUM = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [2:0]        owner_q, owner_d;
   logic [2:0]        ptr_q, ptr_d;
   logic              ack_q, ack_d;
   logic              busy_q, busy_d;
   logic [DW-1:0]     sel_q, sel_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic              ovf_q, ovf_d;

   logic              hi_found_s, lo_found_s, win_found_s;
   logic [2:0]        hi_idx_s, lo_idx_s, win_idx_s;
   logic [NREQ-1:0]   win_onehot_s;
   logic              req_own_s;
   logic [DW-1:0]     data_own_s;
   logic [AW:0]       sum_s;

   function automatic logic [AW:0] acc_sum(input logic [AW-1:0] a, input logic [DW-1:0] b);
      return {1'b0, a} + (AW+1)'(b);
   endfunction

   // Round-robin search: first requester above ptr, otherwise first requester at or below ptr.
   always_comb begin
      hi_found_s = 1'b0;
      lo_found_s = 1'b0;
      hi_idx_s   = 3'd0;
      lo_idx_s   = 3'd0;
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req[i] && (3'(i) > ptr_q) && !hi_found_s) begin
            hi_found_s = 1'b1;
            hi_idx_s   = 3'(i);
         end else if (bus.req[i] && !lo_found_s) begin
            lo_found_s = 1'b1;
            lo_idx_s   = 3'(i);
         end else begin
            hi_found_s = hi_found_s;
         end
      end
      win_found_s = hi_found_s | lo_found_s;
      if (hi_found_s) begin
         win_idx_s = hi_idx_s;
      end else begin
         win_idx_s = lo_idx_s;
      end
   end

   // Decode the winner to one-hot and pick out the current owner's request and addend.
   always_comb begin
      win_onehot_s = '0;
      req_own_s    = 1'b0;
      data_own_s   = '0;
      for (int i = 0; i < NREQ; i++) begin
         win_onehot_s[i] = (3'(i) == win_idx_s);
         if (3'(i) == owner_q) begin
            req_own_s  = bus.req[i];
            data_own_s = bus.data[i*DW +: DW];
         end else begin
            req_own_s  = req_own_s;
         end
      end
   end

   // Sum is one bit wider than the accumulator so the top bit is the carry-out.
   always_comb begin
      sum_s = acc_sum(acc_q, sel_q);
   end

   // Next-state and next-output logic for the transaction FSM.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      ack_d   = 1'b0;
      sel_d   = sel_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.clr_req) begin
               acc_d = '0;
               ovf_d = 1'b0;
               gnt_d = '0;
            end else if (win_found_s) begin
               gnt_d   = win_onehot_s;
               owner_d = win_idx_s;
               state_d = ST_GRANT;
            end else begin
               gnt_d = '0;
            end
         end
         ST_GRANT: begin
            if (req_own_s) begin
               sel_d   = data_own_s;
               state_d = ST_ACCUM;
            end else begin
               // Requester dropped out: abort without touching ptr.
               gnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_ACCUM: begin
`ifdef ACC_SHARE_SAT_EN
            if (sum_s[AW]) begin
               acc_d = {AW{1'b1}};
            end else begin
               acc_d = sum_s[AW-1:0];
            end
`else
            acc_d = sum_s[AW-1:0];
`endif
            ovf_d   = ovf_q | sum_s[AW];
            ack_d   = 1'b1;
            gnt_d   = '0;
            ptr_d   = owner_q;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         owner_q <= 3'd0;
         ptr_q   <= 3'(NREQ-1);
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         sel_q   <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         sel_q   <= sel_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.owner   = owner_q;
   assign bus.ack     = ack_q;
   assign bus.busy    = busy_q;
   assign bus.acc_out = acc_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_acc_share_ctrl.sv
// Self-checking bench for acc_share_ctrl: directed steps plus random transactions against
// a transaction-level model of the accumulator, overflow flag and round-robin pointer.
module tb_acc_share_ctrl;
   localparam int NREQ = 4;
   localparam int DW   = 4;
   localparam int AW   = 8;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   int   m_acc;
   int   m_ovf;
   int   m_ptr;

   acc_share_ctrl_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

   acc_share_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: requesters checked in order ptr+1, ptr+2, ... wrapping modulo NREQ.
   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 1; k <= NREQ; k++) begin
         int c;
         c = (p + k) % NREQ;
         if (((r >> c) & 1) != 0) return c;
      end
      return -1;
   endfunction

   task automatic model_add(input int v);
      int s;
      s = m_acc + v;
      if (s >= (1 << AW)) begin
         m_ovf = 1;
`ifdef ACC_SHARE_SAT_EN
         m_acc = (1 << AW) - 1;
`else
         m_acc = s - (1 << AW);
`endif
      end else begin
         m_acc = s;
      end
   endtask

   task automatic model_reset();
      m_acc = 0;
      m_ovf = 0;
      m_ptr = NREQ - 1;
   endtask

   // One request/grant/accumulate/ack transaction, optionally aborted in GRANT.
   task automatic txn(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d,
                      input bit abort_it, input bit hold);
      int w;
      logic [NREQ-1:0] oh;
      bus.req  = r;
      bus.data = d;
      w = rr_pick(r, m_ptr);
      if (w < 0) begin
         step();
         chk("idle_gnt", 32'(bus.gnt), 32'd0);
         return;
      end
      oh = NREQ'(1 << w);
      step();
      chk("gnt", 32'(bus.gnt), 32'(oh));
      chk("owner", 32'(bus.owner), 32'(w));
      chk("busy_grant", 32'(bus.busy), 32'd1);
      chk("ack_grant", 32'(bus.ack), 32'd0);
      if (abort_it) begin
         bus.req = r & ~oh;
         step();
         chk("abort_gnt", 32'(bus.gnt), 32'd0);
         chk("abort_busy", 32'(bus.busy), 32'd0);
         chk("abort_ack", 32'(bus.ack), 32'd0);
         chk("abort_acc", 32'(bus.acc_out), 32'(m_acc));
         bus.req = '0;
         return;
      end
      step();
      chk("ack_accum", 32'(bus.ack), 32'd0);
      chk("gnt_accum", 32'(bus.gnt), 32'(oh));
      step();
      model_add(int'((d >> (w*DW)) & 16'h000F));
      m_ptr = w;
      chk("ack", 32'(bus.ack), 32'd1);
      chk("acc", 32'(bus.acc_out), 32'(m_acc));
      chk("ovf", 32'(bus.ovf), 32'(m_ovf));
      chk("gnt_done", 32'(bus.gnt), 32'd0);
      chk("busy_done", 32'(bus.busy), 32'd0);
      if (!hold) bus.req = '0;
   endtask

   // Clear in IDLE, with requests possibly asserted to confirm clear wins.
   task automatic clr_op(input logic [NREQ-1:0] r);
      bus.clr_req = 1'b1;
      bus.req     = r;
      step();
      m_acc = 0;
      m_ovf = 0;
      chk("clr_acc", 32'(bus.acc_out), 32'd0);
      chk("clr_ovf", 32'(bus.ovf), 32'd0);
      chk("clr_gnt", 32'(bus.gnt), 32'd0);
      chk("clr_busy", 32'(bus.busy), 32'd0);
      bus.clr_req = 1'b0;
      bus.req     = '0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
      model_reset();
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      bus.req     = '0;
      bus.data    = '0;
      bus.clr_req = 1'b0;
      reset       = 1'b0;
      model_reset();
      #2;
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_owner", 32'(bus.owner), 32'd0);
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_acc", 32'(bus.acc_out), 32'd0);
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
      step();
      reset = 1'b1;
      step();

      txn(4'b0001, 16'h000A, 1'b0, 1'b0);
      chk("single_acc", 32'(bus.acc_out), 32'h0A);

      apply_reset();
      clr_op(4'b1111);
      for (int i = 0; i < 5; i++) begin
         txn(4'b1111, 16'h4321, 1'b0, (i < 4));
      end
      chk("rr_acc", 32'(bus.acc_out), 32'd11);
      chk("rr_owner", 32'(bus.owner), 32'd0);

      clr_op(4'b0000);
      for (int i = 0; i < 16; i++) begin
         txn(4'b0001, 16'h000F, 1'b0, 1'b0);
      end
      txn(4'b0001, 16'h000A, 1'b0, 1'b0);
      chk("preload_acc", 32'(bus.acc_out), 32'hFA);
      txn(4'b0001, 16'h000F, 1'b0, 1'b0);
`ifdef ACC_SHARE_SAT_EN
      chk("ovf_acc", 32'(bus.acc_out), 32'hFF);
`else
      chk("ovf_acc", 32'(bus.acc_out), 32'h09);
`endif
      chk("ovf_flag", 32'(bus.ovf), 32'd1);
      txn(4'b0001, 16'h0001, 1'b0, 1'b0);
      clr_op(4'b0000);

      txn(4'b0010, 16'h0030, 1'b0, 1'b0);
      txn(4'b0100, 16'h0500, 1'b1, 1'b0);
      step();
      chk("abort_idle_acc", 32'(bus.acc_out), 32'h03);
      txn(4'b0110, 16'h0570, 1'b0, 1'b0);
      chk("post_abort_owner", 32'(bus.owner), 32'd2);

      clr_op(4'b0000);
      txn(4'b0001, 16'h000F, 1'b0, 1'b0);
      txn(4'b0001, 16'h0001, 1'b0, 1'b0);
      bus.req  = 4'b0001;
      bus.data = 16'h0005;
      step();
      chk("inflight_gnt", 32'(bus.gnt), 32'h1);
      step();
      bus.clr_req = 1'b1;
      step();
      chk("inflight_acc", 32'(bus.acc_out), 32'h15);
      chk("inflight_ack", 32'(bus.ack), 32'd1);
      bus.req = '0;
      step();
      chk("inflight_clr", 32'(bus.acc_out), 32'h00);
      bus.clr_req = 1'b0;
      model_reset();
      m_ptr = 0;

      txn(4'b0001, 16'h0007, 1'b0, 1'b0);
      bus.req  = 4'b0010;
      bus.data = 16'h0020;
      step();
      chk("midop_gnt_pre", 32'(bus.gnt), 32'h2);
      reset = 1'b0;
      #1;
      chk("midop_gnt", 32'(bus.gnt), 32'd0);
      chk("midop_ack", 32'(bus.ack), 32'd0);
      chk("midop_acc", 32'(bus.acc_out), 32'd0);
      chk("midop_busy", 32'(bus.busy), 32'd0);
      bus.req = '0;
      step();
      reset = 1'b1;
      model_reset();
      step();

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            clr_op(NREQ'($urandom_range(0, 15)));
         end else begin
            txn(NREQ'($urandom_range(1, 15)), 16'($urandom),
                ($urandom_range(0, 9) == 0), 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
